// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot ROM loader: loader FSM state encoding and default memory geometry.
package rom_loader_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    DONE    = 3'd4,
    RUN     = 3'd5
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Serial byte link carrying the program image into the loader.
// A byte transfers on a rising clk edge where rx_valid && rx_ready; rx_data must be stable while rx_valid is high.
interface rom_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/instr_rom.sv
// Instruction memory: one synchronous write port, one asynchronous read port, contents never reset.
module instr_rom #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rom_loader.sv
// Receives a length-prefixed big-endian word stream, writes it into instr_rom and then
// releases the CPU to fetch from it. Illegal lengths leave memory untouched and set a sticky error.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  rom_loader_if.slave       rx,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [15:0]       instruction,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_count,
  output state_t            dbg_state
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        data_hi_q, data_hi_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              load_err_q, load_err_d;
  logic              mem_we;
  logic              accept;
  logic [15:0]       len_full;
  logic [15:0]       rom_rdata;

  assign rx.rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == DATA_HI) || (state_q == DATA_LO);
  assign accept      = rx.rx_valid && rx.rx_ready;
  assign len_full    = {len_hi_q, rx.rx_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LEN_HI;
      len_hi_q     <= '0;
      len_q        <= '0;
      data_hi_q    <= '0;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      data_hi_q    <= data_hi_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      load_err_q   <= load_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    data_hi_d    = data_hi_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    load_err_d   = load_err_q;
    mem_we       = 1'b0;
    case (state_q)
      LEN_HI: if (accept) begin
        len_hi_d = rx.rx_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (accept) begin
        len_d = len_full;
        if (len_full == 16'd0) begin
          state_d = DONE;
        end else if (32'(len_full) > DEPTH) begin
          load_err_d = 1'b1;
          state_d    = RUN;
        end else begin
          load_err_d   = 1'b0;
          wr_addr_d    = '0;
          word_count_d = '0;
          state_d      = DATA_HI;
        end
      end
      DATA_HI: if (accept) begin
        data_hi_d = rx.rx_data;
        state_d   = DATA_LO;
      end
      DATA_LO: if (accept) begin
        mem_we       = 1'b1;
        wr_addr_d    = wr_addr_q + 1'b1;
        word_count_d = word_count_q + 16'd1;
        state_d      = (word_count_q + 16'd1 == len_q) ? DONE : DATA_HI;
      end
      DONE:    state_d = RUN;
      RUN:     if (load_req) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  instr_rom #(.ADDR_W(ADDR_W)) u_instr_rom (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata ({data_hi_q, rx.rx_data}),
    .raddr (pc),
    .rdata (rom_rdata)
  );

  // Fetches are only visible once the CPU is released, so a load never races a read.
  assign instruction = (state_q == RUN) ? rom_rdata : 16'h0000;
  assign cpu_reset   = (state_q != RUN);
  assign load_done   = (state_q == DONE);
  assign load_err    = load_err_q;
  assign word_count  = word_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: stream loads, backpressure, illegal/zero/maximum lengths, reload and reset mid-load.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int ADDR_W = 15;

  logic              clk;
  logic              reset;
  logic              load_req;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instruction;
  logic              cpu_reset;
  logic              load_done;
  logic              load_err;
  logic [15:0]       word_count;
  state_t            dbg_state;

  rom_loader_if rx ();

  rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx.slave),
    .load_req    (load_req),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_err    (load_err),
    .word_count  (word_count),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       exp;
  } rd_vec_t;

  int         checks;
  int         errors;
  int         done_cnt;
  int         exp_done;
  logic [7:0] bytes_q[$];
  rd_vec_t    tab[$];

  always @(negedge clk) if (load_done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent;
    sent = 1'b0;
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    for (int i = 0; i < 20 && !sent; i++) begin
      @(negedge clk);
      if (rx.rx_ready) begin
        @(posedge clk);
        #1;
        sent = 1'b1;
      end
    end
    rx.rx_valid = 1'b0;
    if (!sent) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_all(input bit gaps);
    while (bytes_q.size() > 0) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int i = 0; i < g; i++) begin
          rx.rx_valid = 1'b0;
          rx.rx_data  = 8'($urandom_range(0, 255));
          @(posedge clk);
          #1;
        end
      end
      send_byte(bytes_q.pop_front());
    end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tab.size(); i++) begin
      pc = tab[i].pc;
      step();
      check(name, 32'(instruction), 32'(tab[i].exp));
    end
    tab.delete();
  endtask

  task automatic add_rd(input logic [ADDR_W-1:0] a, input logic [15:0] e);
    rd_vec_t v;
    v.pc  = a;
    v.exp = e;
    tab.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; exp_done = 0;
    reset = 1'b1; load_req = 1'b0; pc = '0;
    rx.rx_valid = 1'b0; rx.rx_data = 8'h00;
    #3;
    check("rst_state", 32'(dbg_state), 32'(LEN_HI));
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_rx_ready", 32'(rx.rx_ready), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Zero length header straight out of reset.
    bytes_q = '{8'h00, 8'h00};
    send_all(1'b0);
    step();
    check("zero_done_pulse", 32'(load_done), 32'd1);
    check("zero_cpu_reset_in_done", 32'(cpu_reset), 32'd1);
    step();
    exp_done++;
    check("zero_state", 32'(dbg_state), 32'(RUN));
    check("zero_load_done_low", 32'(load_done), 32'd0);
    check("zero_word_count", 32'(word_count), 32'd0);
    check("zero_load_err", 32'(load_err), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'(exp_done));

    // Basic load of three words.
    pulse_load_req();
    check("basic_state_after_req", 32'(dbg_state), 32'(LEN_HI));
    bytes_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h80, 8'h01};
    send_all(1'b0);
    step();
    check("basic_done_pulse", 32'(load_done), 32'd1);
    check("basic_cpu_reset_in_done", 32'(cpu_reset), 32'd1);
    step();
    exp_done++;
    check("basic_cpu_released", 32'(cpu_reset), 32'd0);
    check("basic_done_cnt", 32'(done_cnt), 32'(exp_done));
    check("basic_word_count", 32'(word_count), 32'd3);
    add_rd(15'd1, 16'hABCD);
    add_rd(15'd0, 16'h1234);
    add_rd(15'd2, 16'h8001);
    run_table("basic_mem");

    // RUN must ignore incoming bytes.
    rx.rx_data = 8'h5A; rx.rx_valid = 1'b1;
    repeat (3) step();
    check("run_ignores_rx", 32'(dbg_state), 32'(RUN));
    check("run_rx_ready_low", 32'(rx.rx_ready), 32'd0);
    rx.rx_valid = 1'b0;

    // Backpressured load with distinct data.
    pulse_load_req();
    bytes_q = '{8'h00, 8'h03, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    send_all(1'b1);
    repeat (2) step();
    exp_done++;
    check("bp_state", 32'(dbg_state), 32'(RUN));
    check("bp_word_count", 32'(word_count), 32'd3);
    check("bp_done_cnt", 32'(done_cnt), 32'(exp_done));
    add_rd(15'd0, 16'h0F0E);
    add_rd(15'd1, 16'h0D0C);
    add_rd(15'd2, 16'h0B0A);
    run_table("bp_mem");

    // Illegal length DEPTH+1.
    pulse_load_req();
    bytes_q = '{8'h80, 8'h01};
    send_all(1'b0);
    repeat (2) step();
    check("ill_load_err", 32'(load_err), 32'd1);
    check("ill_state", 32'(dbg_state), 32'(RUN));
    check("ill_no_done", 32'(done_cnt), 32'(exp_done));
    check("ill_word_count", 32'(word_count), 32'd3);
    add_rd(15'd0, 16'h0F0E);
    add_rd(15'd2, 16'h0B0A);
    run_table("ill_mem");

    // Length exactly DEPTH is legal and clears the sticky error.
    pulse_load_req();
    bytes_q = '{8'h80, 8'h00};
    send_all(1'b0);
    step();
    check("max_state", 32'(dbg_state), 32'(DATA_HI));
    check("max_load_err", 32'(load_err), 32'd0);
    check("max_word_count", 32'(word_count), 32'd0);
    do_reset();
    bytes_q = '{8'h00, 8'h00};
    send_all(1'b0);
    repeat (2) step();
    exp_done++;
    check("max_recover_state", 32'(dbg_state), 32'(RUN));

    // Reload one word; load_req during DATA_HI is ignored.
    pulse_load_req();
    bytes_q = '{8'h00, 8'h01};
    send_all(1'b0);
    check("reload_in_data_hi", 32'(dbg_state), 32'(DATA_HI));
    pulse_load_req();
    check("reload_req_ignored", 32'(dbg_state), 32'(DATA_HI));
    bytes_q = '{8'h55, 8'hAA};
    send_all(1'b0);
    repeat (2) step();
    exp_done++;
    check("reload_state", 32'(dbg_state), 32'(RUN));
    check("reload_word_count", 32'(word_count), 32'd1);
    check("reload_done_cnt", 32'(done_cnt), 32'(exp_done));
    add_rd(15'd0, 16'h55AA);
    add_rd(15'd1, 16'h0D0C);
    run_table("reload_mem");

    // Reset after 3 of 4 data bytes.
    pulse_load_req();
    bytes_q = '{8'h00, 8'h02, 8'h77, 8'h66, 8'h99};
    send_all(1'b0);
    check("midrst_pre_state", 32'(dbg_state), 32'(DATA_LO));
    pc = 15'd0;
    reset = 1'b1;
    #1;
    check("midrst_state", 32'(dbg_state), 32'(LEN_HI));
    check("midrst_instruction", 32'(instruction), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bytes_q = '{8'h00, 8'h00};
    send_all(1'b0);
    repeat (2) step();
    exp_done++;
    check("midrst_done_cnt", 32'(done_cnt), 32'(exp_done));
    add_rd(15'd0, 16'h7766);
    add_rd(15'd1, 16'h0D0C);
    add_rd(15'd2, 16'h0B0A);
    run_table("midrst_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, 15, instruction-memory address width; depth DEPTH = 2**ADDR_W words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port rx_data  input  8  serial-link byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port load_req  input  1  single-cycle request to reload the program.
REQ-008 SHALL have port pc  input  ADDR_W  fetch address from the CPU.
REQ-009 SHALL have port instruction  output  16  fetched word for the CPU.
REQ-010 SHALL have port cpu_reset  output  1  holds the CPU in reset.
REQ-011 SHALL have port load_done  output  1  one-cycle pulse when a load completes.
REQ-012 SHALL have port load_err  output  1  sticky: the last length header was illegal.
REQ-013 SHALL have port word_count  output  16  number of words written by the current or last load.

Function
REQ-014 SHALL implement the FSM states LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE and RUN.
REQ-015 SHALL accept a byte only when rx_valid && rx_ready at the clock edge, with rx_ready = 1 exactly in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-016 SHALL, in LEN_HI on a byte, latch it as length[15:8] and go to LEN_LO.
REQ-017 SHALL, in LEN_LO on a byte, form length L and branch as follows:
- L == 0: go to DONE.
- L > DEPTH: set load_err and go to RUN, leaving memory unchanged.
- otherwise: clear load_err, clear the write address, clear word_count and go to DATA_HI.
REQ-018 SHALL, in DATA_HI on a byte, latch the high byte and go to DATA_LO.
REQ-019 SHALL, in DATA_LO on a byte, write {hi, byte} to mem[wr_addr], increment wr_addr and word_count, and go to DONE if word_count+1 == L, else to DATA_HI.
REQ-020 SHALL, in DONE, assert load_done for exactly one cycle and go to RUN unconditionally.
REQ-021 SHALL, in RUN, go to LEN_HI on load_req and ignore rx_valid.
REQ-022 SHALL ignore load_req in every state other than RUN.
REQ-023 SHALL drive cpu_reset = 1 in every state except RUN; the CPU leaves reset on the cycle after DONE.
REQ-024 SHALL provide instruction = mem[pc] as a combinational (asynchronous) read in RUN, and 16'h0000 in all other states.
REQ-025 SHALL write memory only in DATA_LO; no read/write collision is possible because reads are only visible in RUN.
REQ-026 SHALL perform the write-address increment modulo DEPTH; the L <= DEPTH rule guarantees no wrap within a legal load.
REQ-027 SHALL NOT initialise or clear memory contents on reset.
REQ-028 SHALL hold the current state while rx_valid is low; there is no timeout.

Reset
REQ-029 SHALL, on reset assertion, immediately force state = LEN_HI, cpu_reset = 1, rx_ready = 1, load_done = 0, load_err = 0, word_count = 0, wr_addr = 0 and instruction = 0.
REQ-030 SHALL, on reset mid-load, abandon the partial load; words already written stay in memory and the next header restarts at address 0.

Structure
REQ-031 SHALL take the state encoding, ADDR_W default and DEPTH from the shared CPU package.
REQ-032 SHALL place the memory array in one sub-module, instr_rom (1 write port, 1 asynchronous read port, width 16, depth DEPTH); the FSM, counters and handshake live in rom_loader.

Verification
REQ-033 SHALL cover basic load: reset, then bytes 00 03 | 12 34 | AB CD | 80 01 -> mem[0..2] = 1234, ABCD, 8001; load_done pulses once; cpu_reset falls the next cycle; pc = 1 gives instruction ABCD.
REQ-034 SHALL cover backpressure: rx_valid toggled randomly across the same stream -> identical memory contents; no byte is lost or duplicated; word_count = 3.
REQ-035 SHALL cover illegal length: header 80 01 with ADDR_W = 15 -> load_err = 1; state RUN; memory unchanged; no load_done pulse.
REQ-036 SHALL cover zero length: header 00 00 -> load_done pulses; RUN is entered; word_count = 0; load_err = 0.
REQ-037 SHALL cover reload and ignored request: in RUN, load_req with header 00 01, word 55 AA -> mem[0] = 55AA and mem[1] retains its old value; a load_req pulsed during DATA_HI has no effect.
REQ-038 SHALL cover reset mid-load: assert reset after 3 of 4 data bytes -> mem[0] is written; state LEN_HI; instruction = 0; cpu_reset = 1.
